// File: rtl/gat_bram_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gat_loader_pkg
// Description : Shared types and constants for the GAT BRAM loader: FSM state
//               encoding, target-memory ids, header field positions and a
//               target-id to one-hot helper.
// Revision    : 1.0 - initial release
// ============================================================================
package gat_loader_pkg;

  // Loader FSM states; ST_CSUM is only reachable in checksum builds
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CSUM = 2'd2
  } state_e;

  // Target memory ids carried in the header
  localparam logic [1:0] TGT_H_DATA    = 2'd0;
  localparam logic [1:0] TGT_NODE_INFO = 2'd1;
  localparam logic [1:0] TGT_WGT       = 2'd2;
  localparam logic [1:0] TGT_SUBGRAPH  = 2'd3;

  // Header word layout: [31:30] target id, [29:0] payload count
  localparam int HDR_TGT_MSB = 31;
  localparam int HDR_TGT_LSB = 30;
  localparam int HDR_CNT_MSB = 29;
  localparam int HDR_CNT_LSB = 0;
  localparam int HDR_CNT_W   = HDR_CNT_MSB - HDR_CNT_LSB + 1;

  // One-hot enable vector for a target id
  function automatic logic [3:0] tgt_onehot(input logic [1:0] tgt);
    logic [3:0] oh;
    case (tgt)
      TGT_H_DATA:    oh = 4'b0001;
      TGT_NODE_INFO: oh = 4'b0010;
      TGT_WGT:       oh = 4'b0100;
      TGT_SUBGRAPH:  oh = 4'b1000;
      default:       oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gat_bram_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : gat_stream_if / gat_bram_wr_if
// Description : Valid/ready word stream feeding the loader, and the shared
//               BRAM write port bundle the loader drives.
// Revision    : 1.0 - initial release
// ============================================================================
interface gat_stream_if #(
  parameter int TOP_WIDTH = 32
);
  logic                 s_valid;
  logic                 s_ready;
  logic [TOP_WIDTH-1:0] s_data;

  modport master (output s_valid, output s_data, input  s_ready);
  modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

interface gat_bram_wr_if #(
  parameter int TOP_WIDTH   = 32,
  parameter int ADDR_W      = 20,
  parameter int NUM_TARGETS = 4
);
  logic [TOP_WIDTH-1:0]   bram_din;
  logic [ADDR_W-1:0]      bram_addra;
  logic [NUM_TARGETS-1:0] bram_ena;
  logic [NUM_TARGETS-1:0] bram_wea;

  modport master (output bram_din, output bram_addra, output bram_ena, output bram_wea);
  modport slave  (input  bram_din, input  bram_addra, input  bram_ena, input  bram_wea);
endinterface
`default_nettype wire

// File: rtl/gat_loader_csum.sv
`default_nettype none
// ============================================================================
// Module      : gat_loader_csum
// Description : Wrapping 32-bit sum of a segment's payload words and an
//               equality compare against the trailer word.
// Revision    : 1.0 - initial release
// ============================================================================
module gat_loader_csum #(
  parameter int W = 32
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         i_start,  // header accepted: restart the sum
  input  wire logic         i_add,    // payload word accepted
  input  wire logic [W-1:0] i_word,   // payload or trailer word
  output logic              o_match   // running sum equals i_word
);

  logic [W-1:0] sum_q;
  logic [W-1:0] sum_d;

  // Next sum: restart on a header, accumulate on each payload word
  always_comb begin
    sum_d = sum_q;
    if (i_start) begin
      sum_d = '0;
    end else if (i_add) begin
      sum_d = sum_q + i_word;
    end
  end

  // Sum register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign o_match = (sum_q == i_word);

endmodule
`default_nettype wire

// File: rtl/gat_bram_loader.sv
`default_nettype none
// ============================================================================
// Module      : gat_bram_loader
// Description : Decodes framed segments (header + payload) from a 32-bit
//               valid/ready stream into one-hot BRAM write sequences for the
//               four GAT memories and raises a sticky per-target load_done.
//               Optional macro LOADER_CHECKSUM_EN adds a trailer word that
//               must equal the wrapping sum of the payload.
// Revision    : 1.0 - initial release
// ============================================================================
module gat_bram_loader
  import gat_loader_pkg::*;
#(
  parameter int TOP_WIDTH   = 32,
  parameter int ADDR_W      = 20,
  parameter int NUM_TARGETS = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              clear,
  gat_stream_if.slave            s,
  gat_bram_wr_if.master          bram,
  output logic [NUM_TARGETS-1:0] load_done,
  output logic                   busy,
  output logic                   err
);

  localparam int IDX_W     = ADDR_W - 2;
  localparam int MAX_WORDS = 1 << IDX_W;
  localparam logic [HDR_CNT_W-1:0] MAX_CNT = HDR_CNT_W'(MAX_WORDS);

  state_e                 state_q, state_d;
  logic                   ready_q, ready_d;
  logic [1:0]             tgt_q, tgt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [TOP_WIDTH-1:0]   din_q, din_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [NUM_TARGETS-1:0] ena_q, ena_d;
  logic [NUM_TARGETS-1:0] done_q, done_d;
  logic                   err_q, err_d;

  logic                   accept;
  logic [HDR_CNT_W-1:0]   hdr_cnt;
  logic                   hdr_ok;
  logic [IDX_W-1:0]       hdr_last;

  assign accept   = s.s_valid && s.s_ready;
  assign hdr_cnt  = s.s_data[HDR_CNT_MSB:HDR_CNT_LSB];
  assign hdr_ok   = (hdr_cnt != '0) && (hdr_cnt <= MAX_CNT);
  // N = MAX_WORDS has zero low bits, so the wrap yields the all-ones index
  assign hdr_last = hdr_cnt[IDX_W-1:0] - IDX_W'(1);

`ifdef LOADER_CHECKSUM_EN
  logic csum_match;

  gat_loader_csum #(
    .W (TOP_WIDTH)
  ) u_csum (
    .clk     (clk),
    .rst     (rst),
    .i_start (accept && !clear && (state_q == ST_IDLE)),
    .i_add   (accept && !clear && (state_q == ST_LOAD)),
    .i_word  (s.s_data),
    .o_match (csum_match)
  );
`endif

  // Next-state and write-port decode; clear overrides any stream activity
  always_comb begin
    state_d = state_q;
    ready_d = 1'b1;
    tgt_d   = tgt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    din_d   = din_q;
    addr_d  = addr_q;
    ena_d   = '0;
    done_d  = done_q;
    err_d   = err_q;
    if (clear) begin
      state_d = ST_IDLE;
      done_d  = '0;
      err_d   = 1'b0;
    end else if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (hdr_ok) begin
            tgt_d   = s.s_data[HDR_TGT_MSB:HDR_TGT_LSB];
            last_d  = hdr_last;
            idx_d   = '0;
            state_d = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
        ST_LOAD: begin
          din_d  = s.s_data;
          addr_d = {idx_q, 2'b00};
          ena_d  = NUM_TARGETS'(tgt_onehot(tgt_q));
          if (idx_q == last_q) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            done_d[tgt_q] = 1'b1;
            state_d       = ST_IDLE;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        ST_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
          if (csum_match) begin
            done_d[tgt_q] = 1'b1;
          end else begin
            err_d = 1'b1;
          end
`endif
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      tgt_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      din_q   <= '0;
      addr_q  <= '0;
      ena_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      tgt_q   <= tgt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      din_q   <= din_d;
      addr_q  <= addr_d;
      ena_q   <= ena_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign s.s_ready       = ready_q && !clear;
  assign bram.bram_din   = din_q;
  assign bram.bram_addra = addr_q;
  assign bram.bram_ena   = ena_q;
  assign bram.bram_wea   = ena_q;
  assign load_done       = done_q;
  assign busy            = (state_q != ST_IDLE);
  assign err             = err_q;

endmodule
`default_nettype wire

// File: doc/gat_bram_loader.md
# gat_bram_loader

Front-end loader that sits directly upstream of the GAT top wrapper's BRAM write ports. It consumes one 32-bit valid/ready word stream carrying framed segments (header + payload), decodes the target memory (H data, H node info, weight, subgraph index), and generates the `din`/`ena`/`wea`/byte-address write sequence for that memory. On a segment's final word it raises that target's sticky `load_done` flag, which drives the wrapper's `*_load_done` inputs.

## Interface
- `TOP_WIDTH`, 32, stream and BRAM data width
- `ADDR_W`, 20, byte-address width of `bram_addra`; word index occupies bits `[ADDR_W-1:2]`
- `MAX_WORDS`, 2^(ADDR_W-2), largest legal payload count
- `NUM_TARGETS`, 4, target memories: 0 = h_data, 1 = h_node_info, 2 = wgt, 3 = subgraph
- Clock: one clock. Reset: asynchronous, active-high.
- `clk`  in  1  single clock
- `rst`  in  1  asynchronous, active-high reset
- `clear`  in  1  synchronous pulse; clears `load_done`, `err`, and aborts any segment
- `s_valid`  in  1  stream word valid
- `s_ready`  out  1  stream word accepted when `s_valid && s_ready`
- `s_data`  in  TOP_WIDTH  header or payload word
- `bram_din`  out  TOP_WIDTH  write data, shared by all targets
- `bram_addra`  out  ADDR_W  byte address (word index << 2), shared
- `bram_ena`  out  NUM_TARGETS  one-hot enable
- `bram_wea`  out  NUM_TARGETS  one-hot write enable, equal to `bram_ena`
- `load_done`  out  NUM_TARGETS  sticky per-target completion
- `busy`  out  1  high while a segment is open
- `err`  out  1  sticky framing error

## Operation
- Header word: `[31:30]` is the target id; `[29:0]` is the payload count N.
- FSM states: IDLE, LOAD, and CSUM (CSUM exists only under the macro).
- IDLE: `s_ready` = 1.
  - An accepted header with 1 ≤ N ≤ MAX_WORDS latches the target and N, clears the word index, and moves to LOAD.
  - N = 0 or N > MAX_WORDS sets `err` and the FSM stays in IDLE. The header is consumed.
- LOAD: `s_ready` = 1.
  - Each accepted word k (0-based) produces one write: `bram_din` = word, `bram_addra` = k<<2, and one-hot ena/wea on the latched target.
  - After word N-1, the FSM sets `load_done[target]` and returns to IDLE.
- A target may be reloaded. The new segment overwrites from address 0, and `load_done` stays set.
- `clear` takes priority over everything. While `clear` is high, `s_ready` = 0 and no word is accepted. On the next cycle the FSM is in IDLE, `load_done` = 0, `err` = 0, and `busy` = 0.
- Address arithmetic: the word index counter is ADDR_W-2 bits. It never wraps because N ≤ MAX_WORDS.
- `busy` = (state != IDLE).

## Timing
- Reset values: `s_ready` = 0 during reset and 1 the first cycle after; `bram_din`, `bram_addra`, `bram_ena`, `bram_wea`, `load_done`, `busy`, and `err` are all 0. FSM is in IDLE.
- Write latency: a payload word accepted at cycle t appears on the BRAM port at t+1, registered. ena/wea are high for exactly that one cycle per word.
- `load_done[target]` rises at t+1 after the last payload is accepted, in the same cycle as the final write.
- Throughput: one word per cycle. `s_valid` gaps insert idle cycles with ena = 0.
- The header costs one cycle and produces no write.
- Reset mid-segment abandons the segment. Partial data already in the BRAM is left as is.

## Configuration
- Macro: `LOADER_CHECKSUM_EN`.
- With the macro defined:
  - A 32-bit wrapping sum of the payload words is accumulated.
  - After word N-1 the FSM enters CSUM and accepts one trailer word, which produces no write.
  - If the trailer equals the sum, `load_done[target]` is set. Otherwise `err` is set and `load_done` is unchanged.
  - `load_done` rises one cycle after the trailer is accepted.
- Without the macro: no trailer is expected, and `load_done` follows the last payload word as above.

## Structure
- Package `gat_loader_pkg` holds:
  - state enum
  - target-id localparams (`TGT_H_DATA`, `TGT_NODE_INFO`, `TGT_WGT`, `TGT_SUBGRAPH`)
  - header field positions
- Sub-module `gat_loader_csum` (accumulator plus compare) is instantiated only under `LOADER_CHECKSUM_EN`.

## Test plan
- Header 0x4000_0003 (target 1, N=3), then 0xA, 0xB, 0xC → writes to ena[1] at addresses 0x0, 0x4, 0x8 with din 0xA, 0xB, 0xC. `load_done` becomes 4'b0010 one cycle after 0xC.
- Header 0x0000_0000 (N=0) → `err` = 1, no writes, FSM back in IDLE. The next valid header loads normally.
- Target 2 with N=2 and `s_valid` gapped by 3 cycles → exactly 2 write pulses, no spurious ena.
- `clear` asserted mid-LOAD (after 1 of 4 words) → `s_ready` = 0 that cycle, then `busy` = 0 and `load_done` = 0. A fresh header is accepted.
- Async `rst` pulse between clock edges during LOAD → all outputs 0 immediately. After release, a full 4-target load sets `load_done` = 4'hF.
- With `LOADER_CHECKSUM_EN`: target 3, N=2 with payload 1, 2:
  - Trailer 3 sets `load_done[3]`.
  - Repeated with trailer 4, `err` = 1 and `load_done[3]` = 0.
